// File: rtl/xaui_link_ctrl_if.sv
// Core-side bundle between the XAUI bring-up sequencer and the XAUI core.
// master = sequencer (drives configuration), slave = core (reports status).
interface xaui_link_ctrl_if;
   logic [6:0] configuration_vector;
   logic       mgt_tx_ready;
   logic [3:0] sync_status;
   logic       align_status;
   logic [7:0] status_vector;

   modport master (
      output configuration_vector,
      input  mgt_tx_ready,
      input  sync_status,
      input  align_status,
      input  status_vector
   );

   modport slave (
      input  configuration_vector,
      output mgt_tx_ready,
      output sync_status,
      output align_status,
      output status_vector
   );
endinterface

// File: rtl/xaui_link_ctrl.sv
// XAUI bring-up/supervision sequencer (clk156 domain): drives the core configuration,
// qualifies sync/alignment before declaring link up, retries on timeout, counts link drops.
module xaui_link_ctrl #(
   parameter int unsigned SYNC_TIMEOUT  = 156250,
   parameter int unsigned STABLE_CYCLES = 1024,
   parameter int unsigned MAX_RETRY     = 8,
   parameter int unsigned CNT_W         = 16
) (
   input  logic               clk156,
   input  logic               reset,
   input  logic               restart,
   input  logic               cfg_loopback,
   input  logic               cfg_power_down,
   input  logic               cfg_test_enable,
   input  logic [1:0]         cfg_test_select,
   xaui_link_ctrl_if.master   core,
   output logic               link_up,
   output logic               link_fail,
   output logic [2:0]         state_o,
   output logic [7:0]         retry_count,
   output logic [CNT_W-1:0]   drop_count
);

   typedef enum logic [2:0] {
      ST_RST        = 3'd0,
      ST_WAIT_TX    = 3'd1,
      ST_CLR        = 3'd2,
      ST_WAIT_SYNC  = 3'd3,
      ST_WAIT_ALIGN = 3'd4,
      ST_QUAL       = 3'd5,
      ST_UP         = 3'd6,
      ST_FAIL       = 3'd7
   } state_t;

   localparam int unsigned TMAX = (SYNC_TIMEOUT > STABLE_CYCLES) ? SYNC_TIMEOUT : STABLE_CYCLES;
   localparam int unsigned TW   = $clog2(TMAX + 1);

   state_t            state, state_nxt;
   logic [TW-1:0]     timer, timer_nxt;
   logic [7:0]        retry_nxt;
   logic [CNT_W-1:0]  drop_nxt, drop_inc;
   logic [6:0]        cfg_q;
   logic              sync_all, good, timeout;

   assign sync_all = &core.sync_status;
   assign good     = sync_all & core.align_status & (core.status_vector == 8'hFC);
   assign drop_inc = (drop_count == '1) ? drop_count : drop_count + 1'b1;

   always_comb begin
      state_nxt = state;
      retry_nxt = retry_count;
      drop_nxt  = drop_count;
      timeout   = 1'b0;

      if (restart) begin
         state_nxt = ST_RST;
         retry_nxt = '0;
      end else if (cfg_power_down) begin
         state_nxt = ST_RST;
      end else if (!core.mgt_tx_ready &&
                   (state inside {ST_CLR, ST_WAIT_SYNC, ST_WAIT_ALIGN, ST_QUAL, ST_UP})) begin
         state_nxt = ST_WAIT_TX;
         if (state == ST_UP) drop_nxt = drop_inc;
      end else begin
         // Advance conditions are tested before the timer so a same-cycle timeout loses.
         unique case (state)
            ST_RST:       state_nxt = ST_WAIT_TX;
            ST_WAIT_TX:   if (core.mgt_tx_ready) state_nxt = ST_CLR;
            ST_CLR:       state_nxt = ST_WAIT_SYNC;
            ST_WAIT_SYNC: begin
               if (sync_all)                              state_nxt = ST_WAIT_ALIGN;
               else if (timer == TW'(SYNC_TIMEOUT - 1))   timeout   = 1'b1;
            end
            ST_WAIT_ALIGN: begin
               if (core.align_status)                     state_nxt = ST_QUAL;
               else if (!sync_all)                        state_nxt = ST_WAIT_SYNC;
               else if (timer == TW'(SYNC_TIMEOUT - 1))   timeout   = 1'b1;
            end
            ST_QUAL: begin
               if (!good)                                 timeout   = 1'b1;
               else if (timer == TW'(STABLE_CYCLES - 1))  state_nxt = ST_UP;
            end
            ST_UP: begin
               if (!good) begin
                  state_nxt = ST_CLR;
                  drop_nxt  = drop_inc;
               end
            end
            ST_FAIL:      state_nxt = ST_FAIL;
            default:      state_nxt = ST_RST;
         endcase

         if (timeout) begin
            if (retry_count == 8'(MAX_RETRY - 1)) begin
               state_nxt = ST_FAIL;
               retry_nxt = 8'(MAX_RETRY);
            end else begin
               state_nxt = ST_CLR;
               retry_nxt = retry_count + 8'd1;
            end
         end
      end

      if (state_nxt == ST_UP && state != ST_UP) retry_nxt = '0;
   end

   // Timer restarts on any state change and saturates instead of wrapping.
   always_comb begin
      timer_nxt = timer;
      if (state_nxt != state)
         timer_nxt = '0;
      else if ((state inside {ST_WAIT_SYNC, ST_WAIT_ALIGN, ST_QUAL}) && timer != '1)
         timer_nxt = timer + 1'b1;
   end

   always_ff @(posedge clk156) begin
      if (reset) begin
         state       <= ST_RST;
         timer       <= '0;
         retry_count <= '0;
         drop_count  <= '0;
         cfg_q       <= '0;
         link_up     <= 1'b0;
         link_fail   <= 1'b0;
      end else begin
         state       <= state_nxt;
         timer       <= timer_nxt;
         retry_count <= retry_nxt;
         drop_count  <= drop_nxt;
         cfg_q       <= {cfg_test_select, cfg_test_enable, {2{state_nxt == ST_CLR}},
                         cfg_power_down, cfg_loopback};
         link_up     <= (state_nxt == ST_UP);
         link_fail   <= (state_nxt == ST_FAIL);
      end
   end

   assign state_o                   = state;
   assign core.configuration_vector = cfg_q;

endmodule

// File: tb/tb_xaui_link_ctrl.sv
// Directed table-driven bench for xaui_link_ctrl; a second instance with a 2-bit
// drop counter shares all stimulus to exercise counter saturation.
module tb_xaui_link_ctrl;

   logic       clk156 = 1'b0;
   logic       reset, restart, cfg_loopback, cfg_power_down, cfg_test_enable;
   logic [1:0] cfg_test_select;
   logic       link_up, link_fail, s_link_up, s_link_fail;
   logic [2:0] state_o, s_state_o;
   logic [7:0] retry_count, s_retry_count;
   logic [15:0] drop_count;
   logic [1:0] s_drop_count;

   int n_vec = 0;
   int n_bad = 0;

   xaui_link_ctrl_if ifa ();
   xaui_link_ctrl_if ifb ();

   always #5 clk156 = ~clk156;

   xaui_link_ctrl #(.SYNC_TIMEOUT(100), .STABLE_CYCLES(16), .MAX_RETRY(3), .CNT_W(16)) dut (
      .clk156(clk156), .reset(reset), .restart(restart), .cfg_loopback(cfg_loopback),
      .cfg_power_down(cfg_power_down), .cfg_test_enable(cfg_test_enable),
      .cfg_test_select(cfg_test_select), .core(ifa.master), .link_up(link_up),
      .link_fail(link_fail), .state_o(state_o), .retry_count(retry_count),
      .drop_count(drop_count)
   );

   xaui_link_ctrl #(.SYNC_TIMEOUT(100), .STABLE_CYCLES(16), .MAX_RETRY(3), .CNT_W(2)) dut_sat (
      .clk156(clk156), .reset(reset), .restart(restart), .cfg_loopback(cfg_loopback),
      .cfg_power_down(cfg_power_down), .cfg_test_enable(cfg_test_enable),
      .cfg_test_select(cfg_test_select), .core(ifb.master), .link_up(s_link_up),
      .link_fail(s_link_fail), .state_o(s_state_o), .retry_count(s_retry_count),
      .drop_count(s_drop_count)
   );

   typedef struct {
      logic        rst, rs, pd, tx;
      logic [3:0]  sync;
      logic        al;
      logic [7:0]  sv;
      logic [3:0]  c;      // {test_select[1:0], test_enable, loopback}
      int          cyc;
      logic [2:0]  st;
      logic [7:0]  rt;
      logic [15:0] dr;
   } vec_t;

   vec_t vt[$];
   vec_t cur;

   function automatic void add(logic rst, logic rs, logic pd, logic tx, logic [3:0] sync,
                               logic al, logic [7:0] sv, logic [3:0] c, int cyc,
                               logic [2:0] st, logic [7:0] rt, logic [15:0] dr);
      vec_t v;
      v.rst = rst; v.rs = rs; v.pd = pd; v.tx = tx; v.sync = sync; v.al = al; v.sv = sv;
      v.c = c; v.cyc = cyc; v.st = st; v.rt = rt; v.dr = dr;
      vt.push_back(v);
   endfunction

   task automatic drive(input vec_t v);
      reset            = v.rst;
      restart          = v.rs;
      cfg_power_down   = v.pd;
      cfg_test_select  = v.c[3:2];
      cfg_test_enable  = v.c[1];
      cfg_loopback     = v.c[0];
      ifa.mgt_tx_ready = v.tx;  ifb.mgt_tx_ready = v.tx;
      ifa.sync_status  = v.sync; ifb.sync_status = v.sync;
      ifa.align_status = v.al;  ifb.align_status = v.al;
      ifa.status_vector = v.sv; ifb.status_vector = v.sv;
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk156);
      #1;
   endtask

   task automatic check(input string name, input logic [2:0] est, input logic [7:0] ert,
                        input logic [15:0] edr, input logic rst_row);
      logic [6:0] ecfg;
      logic [1:0] esat;
      ecfg = rst_row ? 7'd0 : {cfg_test_select, cfg_test_enable,
                               (est == 3'd2) ? 2'b11 : 2'b00, cfg_power_down, cfg_loopback};
      esat = (edr > 16'd3) ? 2'd3 : edr[1:0];
      n_vec++;
      if (state_o !== est || link_up !== (est == 3'd6) || link_fail !== (est == 3'd7) ||
          retry_count !== ert || drop_count !== edr || ifa.configuration_vector !== ecfg ||
          s_state_o !== est || s_drop_count !== esat) begin
         n_bad++;
         $display("FAIL %s: state=%0d want %0d, up=%b fail=%b, retry=%0d want %0d, drop=%0d want %0d, sat_state=%0d sat_drop=%0d want %0d, cfg=%h want %h",
                  name, state_o, est, link_up, link_fail, retry_count, ert, drop_count, edr,
                  s_state_o, s_drop_count, esat, ifa.configuration_vector, ecfg);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached, %0d vectors applied", n_vec);
      $fatal(1, "timeout");
   end

   initial begin
      //   rst rs pd tx sync  al sv     c       cyc  st rt dr
      add(1, 0, 0, 1, 4'hF, 1, 8'hFC, 4'h0,   2,  0, 0, 0);   // reset state
      add(0, 0, 0, 1, 4'hF, 1, 8'hFC, 4'h0,   1,  1, 0, 0);   // clean bring-up
      add(0, 0, 0, 1, 4'hF, 1, 8'hFC, 4'h0,   1,  2, 0, 0);
      add(0, 0, 0, 1, 4'hF, 1, 8'hFC, 4'h0,   1,  3, 0, 0);
      add(0, 0, 0, 1, 4'hF, 1, 8'hFC, 4'h0,   1,  4, 0, 0);
      add(0, 0, 0, 1, 4'hF, 1, 8'hFC, 4'h0,   1,  5, 0, 0);
      add(0, 0, 0, 1, 4'hF, 1, 8'hFC, 4'h0,  15,  5, 0, 0);
      add(0, 0, 0, 1, 4'hF, 1, 8'hFC, 4'h0,   1,  6, 0, 0);
      add(0, 0, 0, 1, 4'hF, 1, 8'hFD, 4'h0,   1,  2, 0, 1);   // drop in UP
      add(0, 0, 0, 1, 4'hF, 1, 8'hFC, 4'h0,   1,  3, 0, 1);
      add(0, 0, 0, 1, 4'hF, 1, 8'hFC, 4'h0,   2,  5, 0, 1);
      add(0, 0, 0, 1, 4'hF, 1, 8'hFC, 4'h0,  16,  6, 0, 1);
      add(0, 0, 1, 1, 4'hF, 1, 8'hFC, 4'h0,   1,  0, 0, 1);   // power down in UP
      add(0, 0, 1, 1, 4'hF, 1, 8'hFC, 4'h0,   5,  0, 0, 1);
      add(0, 0, 0, 1, 4'hF, 1, 8'hFC, 4'h0,   1,  1, 0, 1);
      add(0, 0, 0, 1, 4'hF, 1, 8'hFC, 4'h0,   4,  5, 0, 1);
      add(0, 0, 0, 1, 4'hF, 1, 8'hFC, 4'h0,   3,  5, 0, 1);
      add(0, 0, 0, 0, 4'hF, 1, 8'hFC, 4'h0,   1,  1, 0, 1);   // tx_ready loss in QUAL
      add(0, 0, 0, 0, 4'hF, 1, 8'hFC, 4'h0,   3,  1, 0, 1);
      add(0, 0, 0, 1, 4'hF, 1, 8'hFC, 4'h0,   5,  5, 0, 1);
      add(0, 0, 0, 1, 4'hF, 1, 8'hFC, 4'h0,  15,  6, 0, 1);
      add(0, 0, 0, 1, 4'h7, 1, 8'hFC, 4'h0,   1,  2, 0, 2);   // sync stuck: retries to FAIL
      add(0, 0, 0, 1, 4'h7, 1, 8'hFC, 4'h0,   1,  3, 0, 2);
      add(0, 0, 0, 1, 4'h7, 1, 8'hFC, 4'h0,  99,  3, 0, 2);
      add(0, 0, 0, 1, 4'h7, 1, 8'hFC, 4'h0,   1,  2, 1, 2);
      add(0, 0, 0, 1, 4'h7, 1, 8'hFC, 4'h0, 101,  2, 2, 2);
      add(0, 0, 0, 1, 4'h7, 1, 8'hFC, 4'h0, 101,  7, 3, 2);
      add(0, 0, 0, 1, 4'hF, 1, 8'hFC, 4'h0,  20,  7, 3, 2);
      add(0, 1, 0, 1, 4'hF, 1, 8'hFC, 4'h0,   1,  0, 0, 2);   // restart out of FAIL
      add(0, 0, 0, 1, 4'hF, 1, 8'hFC, 4'h0,   1,  1, 0, 2);
      add(0, 0, 0, 1, 4'hF, 1, 8'hFC, 4'h0,  20,  6, 0, 2);
      add(0, 0, 0, 1, 4'hF, 1, 8'hFD, 4'h0,   1,  2, 0, 3);
      add(0, 0, 0, 1, 4'hF, 1, 8'hFC, 4'h0,   3,  5, 0, 3);
      add(1, 0, 0, 1, 4'hF, 1, 8'hFC, 4'hB,   1,  0, 0, 0);   // reset mid-QUAL
      add(0, 0, 0, 1, 4'hF, 1, 8'hFC, 4'hB,   1,  1, 0, 0);
      add(0, 0, 0, 1, 4'hF, 1, 8'hFC, 4'h0,   1,  2, 0, 0);
      add(0, 0, 0, 1, 4'hF, 1, 8'hFC, 4'h0,   3,  5, 0, 0);
      add(0, 0, 0, 1, 4'hF, 0, 8'hFC, 4'h0,   1,  2, 1, 0);   // !good in QUAL retries
      add(0, 0, 0, 1, 4'hF, 1, 8'hFC, 4'h0,  20,  6, 0, 0);

      for (int i = 0; i < vt.size(); i++) begin
         drive(vt[i]);
         step(vt[i].cyc);
         check($sformatf("vec%0d", i), vt[i].st, vt[i].rt, vt[i].dr, vt[i].rst);
      end

      // Repeated drops: 16-bit counter keeps counting, 2-bit one sticks at 3.
      cur = vt[vt.size() - 1];
      for (int k = 1; k <= 4; k++) begin
         cur.sv = 8'hFD; drive(cur); step(1);
         check($sformatf("drop%0d", k), 3'd2, 8'd0, 16'(k), 1'b0);
         cur.sv = 8'hFC; drive(cur); step(19);
         check($sformatf("relink%0d", k), 3'd6, 8'd0, 16'(k), 1'b0);
      end

      // Restart during CLR cancels the pulse.
      cur.sv = 8'hFD; drive(cur); step(1);
      check("clr_pulse", 3'd2, 8'd0, 16'd5, 1'b0);
      cur.sv = 8'hFC; cur.rs = 1'b1; drive(cur); step(1);
      check("restart_in_clr", 3'd0, 8'd0, 16'd5, 1'b0);
      cur.rs = 1'b0; drive(cur); step(1);
      check("after_restart", 3'd1, 8'd0, 16'd5, 1'b0);

      // WAIT_ALIGN: sync loss restarts the timer, then a full align timeout.
      step(2);
      check("to_wait_sync", 3'd3, 8'd0, 16'd5, 1'b0);
      cur.al = 1'b0; drive(cur); step(1);
      step(50);
      check("wait_align_50", 3'd4, 8'd0, 16'd5, 1'b0);
      cur.sync = 4'h7; drive(cur); step(1);
      check("align_sync_loss", 3'd3, 8'd0, 16'd5, 1'b0);
      cur.sync = 4'hF; drive(cur); step(1);
      step(99);
      check("align_timer_99", 3'd4, 8'd0, 16'd5, 1'b0);
      step(1);
      check("align_timeout", 3'd2, 8'd1, 16'd5, 1'b0);

      // Sync arriving on the timeout cycle advances instead of retrying.
      cur.sync = 4'h7; drive(cur); step(1);
      step(99);
      check("sync_timer_99", 3'd3, 8'd1, 16'd5, 1'b0);
      cur.sync = 4'hF; drive(cur); step(1);
      check("advance_wins", 3'd4, 8'd1, 16'd5, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
